// File: rtl/nibble_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : nibble_deserializer
// Description : Receive end of the nibble datapath. Pairs incoming 4-bit
//               nibbles into bytes (optionally undoing an upstream nibble
//               swap), recovers alignment on a start-of-byte marker and
//               buffers finished bytes in a DEPTH-entry FIFO drained through
//               a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_deserializer #(
  parameter int HI_FIRST = 1,   // 1: first nibble of a pair is the upper nibble
  parameter int DEPTH    = 4    // FIFO depth in bytes, power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               nib_in,
  input  logic                     nib_valid,
  output logic                     nib_ready,
  input  logic                     sof,
  input  logic                     swap_en,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_align
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int AW = $clog2(DEPTH);   // FIFO pointer width
  localparam int LW = AW + 1;          // occupancy width (0..DEPTH inclusive)

  localparam logic [0:0] ST_FIRST  = 1'b0;  // waiting for first nibble of a pair
  localparam logic [0:0] ST_SECOND = 1'b1;  // holding first nibble, waiting for second

  localparam logic          HI_FIRST_BIT = (HI_FIRST != 0);
  localparam logic [LW-1:0] FULL_LEVEL   = LW'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]    state_q,   state_d;
  logic [3:0]    hold_q,    hold_d;      // first nibble of the pair in progress
  logic          order_q,   order_d;     // 1: hold is the upper nibble
  logic          err_q,     err_d;       // misalignment pulse
  logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [LW-1:0] level_q,   level_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic       w_empty;
  logic       w_full;
  logic       w_accept;
  logic       w_pop;
  logic       w_push;
  logic       w_realign;
  logic [7:0] w_pair_byte;

  assign w_empty = (level_q == '0);
  assign w_full  = (level_q == FULL_LEVEL);

  // Readiness depends only on registered state: the first nibble of a pair
  // never pushes, so it is always acceptable; the second one needs a free
  // slot. A pop in the same cycle does not open a slot early, which keeps
  // byte_ready out of the nib_ready timing path.
  assign nib_ready = (state_q == ST_FIRST) | ~w_full;

  assign w_accept  = nib_valid & nib_ready;
  assign w_pop     = ~w_empty & byte_ready;
  assign w_realign = w_accept & (state_q == ST_SECOND) & sof;
  assign w_push    = w_accept & (state_q == ST_SECOND) & ~sof;

  // Assemble the byte from the held nibble and the one arriving now.
  assign w_pair_byte = order_q ? {hold_q, nib_in} : {nib_in, hold_q};

  // --------------------------------------------------------------------------
  // Pairing FSM: tracks which half of a byte the next nibble is, and
  // restarts the pair whenever sof arrives where a second nibble was expected.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    order_d = order_q;
    err_d   = 1'b0;

    if (w_accept) begin
      case (state_q)
        ST_FIRST: begin
          // Order is frozen here so later swap_en changes cannot
          // corrupt the pair already in progress.
          hold_d  = nib_in;
          order_d = HI_FIRST_BIT ^ swap_en;
          state_d = ST_SECOND;
        end
        ST_SECOND: begin
          if (sof) begin
            // The held nibble belonged to a broken pair: drop it, flag
            // the loss and treat this nibble as the start of a new byte.
            hold_d  = nib_in;
            order_d = HI_FIRST_BIT ^ swap_en;
            err_d   = 1'b1;
            state_d = ST_SECOND;
          end else begin
            state_d = ST_FIRST;
          end
        end
        default: begin
          state_d = ST_FIRST;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO next-state: write on push, advance read on pop, occupancy tracks both.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (w_push) begin
      mem_d[wr_ptr_q] = w_pair_byte;
      wr_ptr_d        = wr_ptr_q + 1'b1;   // power-of-two depth wraps naturally
    end

    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;          // idle, or push and pop together
    endcase
  end

  // --------------------------------------------------------------------------
  // Pairing registers, cleared asynchronously so a reset mid-pair leaves no
  // stale half byte behind.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FIRST;
      hold_q  <= 4'h0;
      order_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      order_q <= order_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage and pointers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: head byte is forced to zero when nothing is buffered so the bus
  // never shows a stale entry.
  // --------------------------------------------------------------------------
  assign byte_valid = ~w_empty;
  assign byte_out   = w_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign level      = level_q;
  assign err_align  = err_q;

endmodule
`default_nettype wire
